// File: rtl/trdb_timer_unit.sv
// Trace debugger timestamp source: free-running prescaled cycle counter, captured
// on request and streamed as low/high 32-bit words over a valid/grant handshake.
module trdb_timer_unit #(
    parameter int unsigned TIME_WIDTH     = 64,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      clear_i,
    input  logic                      tu_req_i,
    output logic [31:0]               tu_word_o,
    output logic                      tu_valid_o,
    input  logic                      tu_grant_i,
    output logic                      tu_busy_o,
    output logic                      tu_overflow_o,
    output logic [TIME_WIDTH-1:0]     time_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [TIME_WIDTH-1:0]     count;
    logic [TIME_WIDTH-1:0]     capture;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      overflow;
    logic                      capture_en;
    logic                      overflow_set;
    logic [31:0]               word_hi;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count   <= '0;
            pre_cnt <= '0;
        end else if (clear_i) begin
            count   <= '0;
            pre_cnt <= '0;
        end else if (trace_enable_i) begin
            if (pre_cnt == prescale_i) begin
                pre_cnt <= '0;
                count   <= count + TIME_WIDTH'(1);
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            capture  <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (capture_en)   capture  <= count;
            if (overflow_set) overflow <= 1'b1;
        end
    end

    // A request coinciding with the high-word grant starts the next capture with no bubble.
    always_comb begin
        state_next   = state;
        capture_en   = 1'b0;
        overflow_set = 1'b0;
        case (state)
            IDLE: begin
                if (tu_req_i) begin
                    state_next = SEND_LO;
                    capture_en = 1'b1;
                end
            end
            SEND_LO: begin
                if (tu_req_i)   overflow_set = 1'b1;
                if (tu_grant_i) state_next   = SEND_HI;
            end
            SEND_HI: begin
                if (tu_grant_i) begin
                    if (tu_req_i) begin
                        state_next = SEND_LO;
                        capture_en = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (tu_req_i) begin
                    overflow_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        word_hi                     = '0;
        word_hi[TIME_WIDTH-33:0]    = capture[TIME_WIDTH-1:32];
        case (state)
            SEND_LO: tu_word_o = capture[31:0];
            SEND_HI: tu_word_o = word_hi;
            default: tu_word_o = '0;
        endcase
    end

    assign tu_valid_o    = (state == SEND_LO) || (state == SEND_HI);
    assign tu_busy_o     = (state != IDLE);
    assign tu_overflow_o = overflow;
    assign time_o        = count;

`ifndef SYNTHESIS
    word_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tu_valid_o && !tu_grant_i && !clear_i) |=> $stable(tu_word_o));
    state_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == IDLE) || (state == SEND_LO) || (state == SEND_HI));
`endif

endmodule
